// File: rtl/sonar_eco_emulador.sv
// Ultrasonic-sensor emulator: answers a trigger pulse with an echo whose width
// is distancia (3-digit BCD, cm) times R clocks, after a fixed response delay.
module sonar_eco_emulador #(
  parameter int R      = 10,
  parameter int N      = 4,
  parameter int T_TRIG = 10,
  parameter int ATRASO = 50,
  parameter int NA     = 6
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        trigger,
  input  logic [11:0] distancia,
  output logic        echo,
  output logic        pronto,
  output logic        fim,
  output logic        erro,
  output logic [2:0]  db_estado
);

  localparam int LW = $clog2(T_TRIG + 1);

  localparam logic [2:0] ST_OCIOSO    = 3'b000;
  localparam logic [2:0] ST_MEDE_TRIG = 3'b001;
  localparam logic [2:0] ST_ATRASO    = 3'b010;
  localparam logic [2:0] ST_ECO       = 3'b011;
  localparam logic [2:0] ST_FIM       = 3'b100;
  localparam logic [2:0] ST_ERRO      = 3'b101;

  logic [2:0]    estado_q,  estado_d;
  logic [LW-1:0] largura_q, largura_d;
  logic [NA-1:0] atraso_q,  atraso_d;
  logic [N-1:0]  tick_q,    tick_d;
  logic [11:0]   bcd_q,     bcd_d;
  logic          echo_q,    echo_d;
  logic [11:0]   bcd_menos_um;

  // Decrement by one with digit borrow; 000 is never decremented in use.
  function automatic logic [11:0] bcd_dec(input logic [11:0] v);
    logic [3:0] d2, d1, d0;
    d2 = v[11:8];
    d1 = v[7:4];
    d0 = v[3:0];
    if (d0 != 4'd0) begin
      d0 = d0 - 4'd1;
    end else begin
      d0 = 4'd9;
      if (d1 != 4'd0) begin
        d1 = d1 - 4'd1;
      end else begin
        d1 = 4'd9;
        d2 = d2 - 4'd1;
      end
    end
    return {d2, d1, d0};
  endfunction

  function automatic logic bcd_valido(input logic [11:0] v);
    return (v[11:8] <= 4'd9) && (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

  assign bcd_menos_um = bcd_dec(bcd_q);

  always_comb begin
    estado_d  = estado_q;
    largura_d = largura_q;
    atraso_d  = atraso_q;
    tick_d    = tick_q;
    bcd_d     = bcd_q;
    echo_d    = echo_q;
    case (estado_q)
      ST_OCIOSO: begin
        if (trigger) begin
          estado_d  = ST_MEDE_TRIG;
          largura_d = LW'(1);
        end
      end
      ST_MEDE_TRIG: begin
        if (trigger) begin
          if (largura_q < LW'(T_TRIG)) begin
            largura_d = largura_q + LW'(1);
          end
        end else if ((largura_q >= LW'(T_TRIG)) && bcd_valido(distancia)) begin
          bcd_d    = distancia;
          atraso_d = '0;
          estado_d = ST_ATRASO;
        end else begin
          estado_d = ST_ERRO;
        end
      end
      ST_ATRASO: begin
        if (atraso_q == NA'(ATRASO - 1)) begin
          if (bcd_q != 12'h000) begin
            estado_d = ST_ECO;
            tick_d   = '0;
            echo_d   = 1'b1;
          end else begin
            estado_d = ST_FIM;
          end
        end else begin
          atraso_d = atraso_q + NA'(1);
        end
      end
      ST_ECO: begin
        // Each wrap of the tick counter is one centimetre of echo.
        if (tick_q == N'(R - 1)) begin
          tick_d = '0;
          bcd_d  = bcd_menos_um;
          if (bcd_menos_um == 12'h000) begin
            estado_d = ST_FIM;
            echo_d   = 1'b0;
          end
        end else begin
          tick_d = tick_q + N'(1);
        end
      end
      ST_FIM: begin
        estado_d = ST_OCIOSO;
      end
      ST_ERRO: begin
        estado_d = ST_OCIOSO;
      end
      default: begin
        estado_d = ST_OCIOSO;
        echo_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado_q  <= ST_OCIOSO;
      largura_q <= '0;
      atraso_q  <= '0;
      tick_q    <= '0;
      bcd_q     <= '0;
      echo_q    <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      largura_q <= largura_d;
      atraso_q  <= atraso_d;
      tick_q    <= tick_d;
      bcd_q     <= bcd_d;
      echo_q    <= echo_d;
    end
  end

  assign echo      = echo_q;
  assign pronto    = (estado_q == ST_OCIOSO);
  assign fim       = (estado_q == ST_FIM);
  assign erro      = (estado_q == ST_ERRO);
  assign db_estado = estado_q;

endmodule

// File: tb/tb_sonar_eco_emulador.sv
// Directed bench for sonar_eco_emulador: latency, echo width, rejection,
// BCD boundaries, trigger interference and asynchronous reset.
module tb_sonar_eco_emulador;

  logic        clock;
  logic        reset_n;
  logic        trigger;
  logic [11:0] distancia;
  logic        echo;
  logic        pronto;
  logic        fim;
  logic        erro;
  logic [2:0]  db_estado;

  int checks   = 0;
  int failures = 0;

  sonar_eco_emulador #(
    .R(10), .N(4), .T_TRIG(10), .ATRASO(50), .NA(6)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .trigger(trigger),
    .distancia(distancia),
    .echo(echo),
    .pronto(pronto),
    .fim(fim),
    .erro(erro),
    .db_estado(db_estado)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Trigger high for tw edges, then low; returns just after edge k.
  task automatic pulse(input int tw, input logic [11:0] d);
    distancia = d;
    trigger   = 1'b1;
    repeat (tw) step();
    trigger = 1'b0;
    step();
  endtask

  task automatic wait_rise(input string tag, input int exp_lat);
    int l;
    l = 0;
    while (echo !== 1'b1 && l < exp_lat + 20) begin
      step();
      l++;
    end
    chk(tag, l, exp_lat);
  endtask

  task automatic wait_fall(input string tag, input int exp_w);
    int w;
    w = 0;
    while (echo === 1'b1 && w < 12000) begin
      step();
      w++;
    end
    chk({tag, "_width"}, w, exp_w);
    chk({tag, "_fim"}, fim, 1);
    chk({tag, "_st_fim"}, db_estado, 3'b100);
    step();
    chk({tag, "_fim_end"}, fim, 0);
    chk({tag, "_pronto"}, pronto, 1);
  endtask

  task automatic reject(input string tag, input int tw, input logic [11:0] d);
    bit seen;
    pulse(tw, d);
    chk({tag, "_erro"}, erro, 1);
    chk({tag, "_st"}, db_estado, 3'b101);
    step();
    chk({tag, "_erro_end"}, erro, 0);
    chk({tag, "_pronto"}, pronto, 1);
    seen = 1'b0;
    repeat (60) begin
      step();
      if (echo !== 1'b0) seen = 1'b1;
    end
    chk({tag, "_no_echo"}, seen, 0);
  endtask

  initial begin
    int w;
    int l;
    bit seen;
    reset_n   = 1'b0;
    trigger   = 1'b0;
    distancia = 12'h000;
    repeat (3) step();
    chk("rst_echo", echo, 0);
    chk("rst_fim", fim, 0);
    chk("rst_erro", erro, 0);
    chk("rst_pronto", pronto, 1);
    chk("rst_estado", db_estado, 3'b000);
    reset_n = 1'b1;
    repeat (5) step();
    chk("idle_pronto", pronto, 1);
    chk("idle_estado", db_estado, 3'b000);

    // Nominal 25 cm
    pulse(10, 12'h025);
    chk("nom_st_atraso", db_estado, 3'b010);
    chk("nom_pronto_busy", pronto, 0);
    wait_rise("nom_lat", 50);
    wait_fall("nom", 250);

    reject("rej_short", 9, 12'h025);
    reject("rej_bcd", 10, 12'h0A3);

    // Zero distance: fim at k+50, no echo
    pulse(10, 12'h000);
    chk("zero_st", db_estado, 3'b010);
    l = 0;
    seen = 1'b0;
    while (fim !== 1'b1 && l < 80) begin
      step();
      l++;
      if (echo !== 1'b0) seen = 1'b1;
    end
    chk("zero_fim_lat", l, 50);
    chk("zero_no_echo", seen, 0);
    step();
    chk("zero_pronto", pronto, 1);

    pulse(10, 12'h999);
    wait_rise("max_lat", 50);
    wait_fall("max", 9990);

    pulse(10, 12'h100);
    wait_rise("borrow_lat", 50);
    wait_fall("borrow", 1000);

    // Interference: re-trigger and distance change mid-echo, trigger held through FIM
    pulse(10, 12'h012);
    wait_rise("intf_lat", 50);
    w = 0;
    while (echo === 1'b1 && w < 2000) begin
      trigger   = ((w >= 30) && (w < 45)) || (w >= 110);
      distancia = (w >= 110) ? 12'h003 : ((w >= 30) ? 12'h999 : 12'h012);
      step();
      w++;
    end
    chk("intf_width", w, 120);
    chk("intf_fim", fim, 1);
    step();
    chk("intf_back_idle", db_estado, 3'b000);
    step();
    chk("intf_retrig", db_estado, 3'b001);
    repeat (9) step();
    trigger = 1'b0;
    step();
    chk("intf_accept", db_estado, 3'b010);
    wait_rise("intf2_lat", 50);
    wait_fall("intf2", 30);

    // Asynchronous reset in the middle of an echo
    pulse(10, 12'h050);
    wait_rise("arst_lat", 50);
    repeat (100) step();
    chk("arst_echo_before", echo, 1);
    reset_n = 1'b0;
    #1;
    chk("arst_echo_drop", echo, 0);
    chk("arst_estado", db_estado, 3'b000);
    step();
    reset_n = 1'b1;
    step();
    pulse(10, 12'h007);
    wait_rise("post_lat", 50);
    wait_fall("post", 70);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sonar_eco_emulador.md
# sonar_eco_emulador

Ultrasonic-sensor emulator: behaves as the sensor end of the trigger/echo ranging interface. It receives a trigger pulse from the ranging controller and, after a fixed response delay, drives an echo pulse whose width is exactly `distancia × R` clocks. This matches the clocks-per-cm scaling used by the team's cm-counting datapath. It replaces the physical sensor in simulation and in FPGA loopback tests of the measurement chain.

## Interface
- `R`, 10: clocks per cm; must equal the receiver's clocks/cm ratio.
- `N`, 4: ceil(log2(R)); width of the per-cm tick counter.
- `T_TRIG`, 10: minimum trigger high width in clocks.
- `ATRASO`, 50: clocks from trigger falling edge to echo rising edge; must be ≥ 1.
- `NA`, 6: ceil(log2(ATRASO+1)).

Ports:
- `clock`  in  1: single clock; all logic on rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `trigger`  in  1: trigger request from the controller; synchronous to `clock`.
- `distancia`  in  12: simulated distance as 3 BCD digits, [11:8]=hundreds, [7:4]=tens, [3:0]=units.
- `echo`  out  1: echo pulse; registered output.
- `pronto`  out  1: high while idle and able to accept a trigger.
- `fim`  out  1: one-cycle pulse at the end of a successful response.
- `erro`  out  1: one-cycle pulse when a trigger is rejected.
- `db_estado`  out  3: current FSM state, for debug.

## Operation
- FSM states and encodings:
  - OCIOSO=000
  - MEDE_TRIG=001
  - ATRASO=010
  - ECO=011
  - FIM=100
  - ERRO=101
- OCIOSO: `pronto`=1. `trigger`=1 → MEDE_TRIG; the trigger-width counter loads 1.
- MEDE_TRIG: while `trigger`=1, the width counter increments, saturating at T_TRIG.
  - On `trigger`=0 with width ≥ T_TRIG and all three digits ≤ 9: latch `distancia` into a 3-digit BCD down-counter, clear the delay counter → ATRASO.
  - On `trigger`=0 with width < T_TRIG or any digit > 9 → ERRO.
- ATRASO: the delay counter counts up. At count ATRASO−1:
  - latched distance ≠ 000 → ECO, with the tick counter cleared;
  - latched distance = 000 → FIM, and no echo is produced.
- ECO: `echo`=1. The mod-R tick counter runs; each wrap decrements the BCD down-counter by 1 with digit borrow (x0 → x−1,9).
  - The wrap that brings the BCD down-counter to 000 → FIM.
- FIM: `fim`=1 for one cycle → OCIOSO.
- ERRO: `erro`=1 for one cycle → OCIOSO.
- `trigger` is ignored in ATRASO, ECO, FIM and ERRO. A trigger still high on return to OCIOSO starts a new MEDE_TRIG.
- `distancia` is sampled only at the MEDE_TRIG→ATRASO transition; later changes have no effect on the current response.

## Timing
- Reset (async, `reset_n`=0) state:
  - state OCIOSO;
  - `echo`=0, `fim`=0, `erro`=0;
  - `pronto`=1, `db_estado`=000;
  - all counters 0.
- Asserting `reset_n` during ECO drops `echo` immediately, without waiting for a clock edge.
- Let edge k be the first rising edge at which `trigger` is sampled low in MEDE_TRIG:
  - state = ATRASO from edge k;
  - `echo` rises at edge k+ATRASO;
  - `echo` stays high for exactly d·R cycles, d = 100·d2 + 10·d1 + d0 (range 1..999);
  - `fim` is high for the single cycle starting at the edge where `echo` falls.
- d=000: `fim` is high from edge k+ATRASO, and `echo` never rises.
- Trigger width = number of consecutive clock edges at which `trigger` is sampled high. Exactly T_TRIG is accepted.
- `pronto` is a decode of state==OCIOSO; `echo` is a dedicated flop, so it is glitch-free.

## Test plan
- Reset: hold `reset_n`=0 → `echo`=0, `fim`=0, `erro`=0, `pronto`=1, `db_estado`=000; after release, stays idle with `trigger`=0.
- Nominal (R=10, T_TRIG=10, ATRASO=50): `trigger` high 10 cycles, `distancia`=0x025 → `echo` rises 50 cycles after trigger falls, high exactly 250 cycles; `fim` pulses 1 cycle at fall; `pronto` returns to 1.
- Rejection: `trigger` high 9 cycles → `erro` one-cycle pulse, no echo. Separately, `distancia`=0x0A3 with a 10-cycle trigger → `erro`, no echo.
- Boundaries:
  - `distancia`=0x000 → no echo, `fim` at k+50;
  - `distancia`=0x999 → echo width 9990 cycles;
  - `distancia`=0x100 → 1000 cycles (borrow chain through both lower digits).
- Interference: re-pulse `trigger` and change `distancia` mid-ECO → echo width unchanged; a trigger held through FIM starts a new measurement.
- Reset mid-operation: drop `reset_n` 100 cycles into ECO → `echo`=0 immediately. After release, a fresh 10-cycle trigger with 0x007 → 70-cycle echo.
